// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - datapath <-> data memory controller bus
//
// Purpose: groups the load/store request and response signals between the
//          datapath (master) and the data memory controller (slave).
// Signals:
//   MemRead   master->slave  load request
//   MemWrite  master->slave  store request
//   addr      master->slave  32-bit byte address
//   WriteData master->slave  32-bit store data
//   ReadData  slave->master  registered load data
//   stall     slave->master  access pending, hold PC/register file
//   misalign  slave->master  one-cycle misaligned-access pulse
interface data_mem_ctrl_if;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] addr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        stall;
   logic        misalign;

   modport master (
      output MemRead, MemWrite, addr, WriteData,
      input  ReadData, stall, misalign
   );

   modport slave (
      input  MemRead, MemWrite, addr, WriteData,
      output ReadData, stall, misalign
   );
endinterface

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - multi-cycle data RAM controller with stall
//
// Purpose: single-port 32-bit word data RAM behind an IDLE/WAIT/DONE FSM.
//          Every access stalls the datapath for 1+WAIT_CYCLES cycles and
//          completes in the one-cycle DONE state.
// Parameters:
//   DEPTH        RAM size in 32-bit words (power of 2, 4..1024)
//   WAIT_CYCLES  wait cycles per access (1..15)
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset (RAM contents are kept)
//   bus    data_mem_ctrl_if.slave (MemRead, MemWrite, addr, WriteData,
//          ReadData, stall, misalign)
// Build option:
//   DMEM_MISALIGN_CHECK_EN  when defined, requests with addr[1:0]!=0 write
//                           nothing, return 0 and pulse misalign in DONE;
//                           otherwise addr[1:0] is ignored and misalign is 0.
module data_mem_ctrl #(
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic           clk,
   input  logic           reset,
   data_mem_ctrl_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

`ifdef DMEM_MISALIGN_CHECK_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t        state;
   logic [3:0]    cnt;
   logic [AW-1:0] req_idx;
   logic [31:0]   req_data;
   logic          req_wr;
   logic          req_rd;
   logic          req_mis;
   logic [31:0]   read_data;
   logic          misalign_q;
   logic          mem_we;

   logic [31:0]   mem [DEPTH];

   // Only the word index is stored; the upper address bits wrap and the
   // byte offset matters only for the misalignment check.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.addr[31:AW+2], bus.addr[1:0]};

   // stall must rise in the same cycle the request appears so the PC holds
   // before the FSM has even left IDLE.
   assign bus.stall    = ((state == IDLE) && (bus.MemRead || bus.MemWrite)) ||
                         (state == WAIT);
   assign bus.ReadData = read_data;
   assign bus.misalign = misalign_q;

   // The RAM write fires on the WAIT->DONE edge. Reset forces IDLE
   // asynchronously, which kills an in-flight write.
   assign mem_we = (state == WAIT) && (cnt == 4'd0) && req_wr && !req_mis;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[req_idx] <= req_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         req_idx    <= '0;
         req_data   <= 32'd0;
         req_wr     <= 1'b0;
         req_rd     <= 1'b0;
         req_mis    <= 1'b0;
         read_data  <= 32'd0;
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.MemRead || bus.MemWrite) begin
                  req_idx  <= bus.addr[AW+1:2];
                  req_data <= bus.WriteData;
                  req_wr   <= bus.MemWrite;
                  req_rd   <= bus.MemRead;
                  req_mis  <= MIS_EN && (bus.addr[1:0] != 2'b00);
                  cnt      <= 4'(WAIT_CYCLES - 1);
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state <= DONE;
                  if (req_mis) begin
                     read_data  <= 32'd0;
                     misalign_q <= 1'b1;
                  end else if (req_wr) begin
                     // Simultaneous read+write behaves as a write that also
                     // returns the stored word; plain writes leave ReadData.
                     if (req_rd) begin
                        read_data <= req_data;
                     end
                  end else begin
                     read_data <= mem[req_idx];
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
